// File: rtl/lift_pkg.sv
// Shared types and helpers for the hall-call dispatcher.
// Direction codes, FSM states and the floor-distance cost.
package lift_pkg;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  localparam int CW = 16;

  typedef enum logic [1:0] {
    SCAN,
    EVAL,
    ISSUE
  } state_t;

  function automatic logic [CW-1:0] floor_cost(
    input logic [CW-1:0] a,
    input logic [CW-1:0] b
  );
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic logic dir_serves(
    input logic [1:0] dir,
    input logic       up
  );
    return (dir == DIR_IDLE) ||
           (up ? (dir == DIR_UP) : (dir == DIR_DN));
  endfunction

endpackage

// File: rtl/lift_cost_select.sv
// Eligibility filter and nearest-car argmin for one hall call.
// Ties resolve to the lowest car index.
module lift_cost_select
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS  = 11,
  parameter int NUM_LIFTS   = 4,
  parameter int MAX_PENDING = 3,
  parameter int PW          = 5,
  localparam int FW = $clog2(NUM_FLOORS),
  localparam int LW = (NUM_LIFTS > 1) ? $clog2(NUM_LIFTS) : 1
) (
  input  logic [NUM_LIFTS*FW-1:0] floors_i,
  input  logic [NUM_LIFTS*2-1:0]  dirs_i,
  input  logic [NUM_LIFTS*PW-1:0] pending_i,
  input  logic [FW-1:0]           call_floor_i,
  input  logic                    call_up_i,
  input  logic                    age_override_i,
  output logic                    found_o,
  output logic [LW-1:0]           index_o
);

  always_comb begin
    logic [CW-1:0] best;
    logic [CW-1:0] c;
    logic [FW-1:0] fl;
    logic [1:0]    dr;
    logic [PW-1:0] pd;
    logic          cap;
    logic          dir_ok;
    logic          found;
    logic [LW-1:0] idx;
    best   = '1;
    c      = '0;
    fl     = '0;
    dr     = '0;
    pd     = '0;
    cap    = 1'b0;
    dir_ok = 1'b0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_LIFTS; k++) begin
      fl  = floors_i[k*FW +: FW];
      dr  = dirs_i[k*2 +: 2];
      pd  = pending_i[k*PW +: PW];
      cap = age_override_i || (int'(pd) < MAX_PENDING);
      dir_ok = (dr == DIR_IDLE) ||
               (dr == DIR_UP && call_up_i &&
                fl <= call_floor_i) ||
               (dr == DIR_DN && !call_up_i &&
                fl >= call_floor_i);
      c = floor_cost(CW'(fl), CW'(call_floor_i));
      if (cap && dir_ok && (!found || c < best)) begin
        found = 1'b1;
        best  = c;
        idx   = LW'(k);
      end
    end
    found_o = found;
    index_o = idx;
  end

endmodule

// File: rtl/lift_dispatcher.sv
// Hall-call latch, scan FSM and per-car assignment handshake.
// Optional call aging: define LIFT_DISPATCH_AGING_EN.
module lift_dispatcher
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS  = 11,
  parameter int NUM_LIFTS   = 4,
  parameter int MAX_PENDING = 3,
  parameter int AGE_LIMIT   = 255,
  localparam int FW = $clog2(NUM_FLOORS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_FLOORS-1:0]   hall_up,
  input  logic [NUM_FLOORS-1:0]   hall_dn,
  input  logic [NUM_LIFTS*FW-1:0] lift_floor,
  input  logic [NUM_LIFTS*2-1:0]  lift_dir,
  input  logic [NUM_LIFTS-1:0]    lift_arrive,
  output logic [NUM_LIFTS-1:0]    assign_valid,
  input  logic [NUM_LIFTS-1:0]    assign_ready,
  output logic [FW-1:0]           assign_floor,
  output logic                    assign_up,
  output logic [NUM_FLOORS-1:0]   up_lamp,
  output logic [NUM_FLOORS-1:0]   dn_lamp
);

  localparam int NS  = 2 * NUM_FLOORS;
  localparam int SPW = $clog2(NS);
  localparam int PW  = $clog2(NS + 1);
  localparam int LW  = (NUM_LIFTS > 1) ? $clog2(NUM_LIFTS) : 1;

  state_t                       state_q;
  logic [SPW-1:0]               ptr_q;
  logic [SPW-1:0]               ptr_nx;
  logic [LW-1:0]                win_q;
  logic [NUM_LIFTS-1:0]         av_q;
  logic [FW-1:0]                af_q;
  logic                         au_q;

  logic [NS-1:0]                lat_q;
  logic [NS-1:0]                asg_q;
  logic [LW-1:0]                own_q [NS];
  logic [NS-1:0]                press;
  logic [NS-1:0]                clr;

  logic [NUM_LIFTS-1:0][PW-1:0] pend_q;
  logic [NUM_LIFTS-1:0][PW-1:0] pend_d;
  logic [NUM_LIFTS-1:0][PW-1:0] n_clr;

  logic                         ptr_up;
  logic [FW-1:0]                ptr_floor;
  logic                         hs;
  logic                         age_ovr;
  logic                         found;
  logic [LW-1:0]                win_idx;

  // Slots 0..F-1 are up calls, F..2F-1 are down calls.
  always_comb begin
    ptr_up    = ptr_q < SPW'(NUM_FLOORS);
    ptr_floor = FW'(ptr_up ? ptr_q
                           : ptr_q - SPW'(NUM_FLOORS));
    ptr_nx    = (ptr_q == SPW'(NS - 1)) ? '0
                                        : ptr_q + 1'b1;
  end

  assign hs = |(av_q & assign_ready);

  always_comb begin
    press = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      press[f] = hall_up[f] && (f != NUM_FLOORS - 1);
      press[NUM_FLOORS+f] = hall_dn[f] && (f != 0);
    end
  end

  always_comb begin
    clr   = '0;
    n_clr = '0;
    for (int s = 0; s < NS; s++) begin
      for (int k = 0; k < NUM_LIFTS; k++) begin
        if (lift_arrive[k] && asg_q[s] &&
            own_q[s] == LW'(k) &&
            lift_floor[k*FW +: FW] ==
              FW'(s < NUM_FLOORS ? s : s - NUM_FLOORS) &&
            dir_serves(lift_dir[k*2 +: 2],
                       s < NUM_FLOORS)) begin
          clr[s]   = 1'b1;
          n_clr[k] = n_clr[k] + PW'(1);
        end
      end
    end
  end

  always_comb begin
    int t;
    t      = 0;
    pend_d = pend_q;
    for (int k = 0; k < NUM_LIFTS; k++) begin
      t = int'(pend_q[k]) - int'(n_clr[k]) +
          ((hs && win_q == LW'(k)) ? 1 : 0);
      pend_d[k] = (t < 0) ? '0 : PW'(t);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // A clear wins over a same-cycle press; it re-latches next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_q <= '0;
      asg_q <= '0;
      for (int s = 0; s < NS; s++) begin
        own_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NS; s++) begin
        if (clr[s]) begin
          lat_q[s] <= 1'b0;
          asg_q[s] <= 1'b0;
        end else if (hs && ptr_q == SPW'(s)) begin
          asg_q[s] <= 1'b1;
          own_q[s] <= win_q;
        end else if (!lat_q[s] && press[s]) begin
          lat_q[s] <= 1'b1;
        end
      end
    end
  end

`ifdef LIFT_DISPATCH_AGING_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);

  logic [AW-1:0] age_q [NS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NS; s++) begin
        age_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NS; s++) begin
        if (!lat_q[s] || asg_q[s]) begin
          age_q[s] <= '0;
        end else if (age_q[s] < AW'(AGE_LIMIT)) begin
          age_q[s] <= age_q[s] + 1'b1;
        end
      end
    end
  end

  assign age_ovr = age_q[ptr_q] >= AW'(AGE_LIMIT);
`else
  // Aging disabled: the capacity limit always applies.
  assign age_ovr = (AGE_LIMIT < 0);
`endif

  lift_cost_select #(
    .NUM_FLOORS  (NUM_FLOORS),
    .NUM_LIFTS   (NUM_LIFTS),
    .MAX_PENDING (MAX_PENDING),
    .PW          (PW)
  ) u_sel (
    .floors_i       (lift_floor),
    .dirs_i         (lift_dir),
    .pending_i      (pend_q),
    .call_floor_i   (ptr_floor),
    .call_up_i      (ptr_up),
    .age_override_i (age_ovr),
    .found_o        (found),
    .index_o        (win_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCAN;
      ptr_q   <= '0;
      win_q   <= '0;
      av_q    <= '0;
      af_q    <= '0;
      au_q    <= 1'b0;
    end else begin
      unique case (state_q)
        SCAN: begin
          if (lat_q[ptr_q] && !asg_q[ptr_q]) begin
            state_q <= EVAL;
          end else begin
            ptr_q <= ptr_nx;
          end
        end
        EVAL: begin
          if (found) begin
            win_q   <= win_idx;
            av_q    <= NUM_LIFTS'(1) << win_idx;
            af_q    <= ptr_floor;
            au_q    <= ptr_up;
            state_q <= ISSUE;
          end else begin
            ptr_q   <= ptr_nx;
            state_q <= SCAN;
          end
        end
        ISSUE: begin
          if (hs) begin
            av_q    <= '0;
            ptr_q   <= ptr_nx;
            state_q <= SCAN;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign assign_valid = av_q;
  assign assign_floor = af_q;
  assign assign_up    = au_q;
  assign up_lamp      = lat_q[NUM_FLOORS-1:0];
  assign dn_lamp      = lat_q[NS-1:NUM_FLOORS];

endmodule
